xrisc_data_responder: RTL and testbench

Data-port responder for the single-cycle XRISC core: the memory side of the core's `MemWrite`/address/`WriteData`/`ReadData` interface. It provides:

- a word-addressed data RAM;
- a free-running cycle counter;
- an LED output register;
- a byte-wide transmit FIFO that an off-core sink drains over a valid/ready stream.

Reads are combinational so the core completes loads in its single cycle. All state updates occur on the rising clock edge.

---
 rtl/xrisc_data_responder.sv | 113 +++++++++++
 tb/tb_xrisc_data_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/xrisc_data_responder.sv
// xrisc_data_responder: data-port RAM, cycle counter, LED register
// and byte transmit FIFO behind the core's load/store interface.
module xrisc_data_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] Leds,
  output logic        TxValid,
  output logic [7:0]  TxData,
  input  logic        TxReady
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [31:0]   cycle;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic          is_ram;
  logic          is_mmio;
  logic [1:0]    sel;
  logic [AW-1:0] idx;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          do_push;
  logic [4:0]    cnt5;
  logic [31:0]   status;
  logic          unused_ok;

  assign is_ram  = DataAdr[31:16] == 16'h0000;
  assign is_mmio = DataAdr[31:4] == 28'hFFFF000;
  assign sel     = DataAdr[3:2];
  assign idx     = DataAdr[AW+1:2];
  assign unused_ok = ^DataAdr;

  assign full    = count == CW'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign TxValid = !empty;
  assign TxData  = fifo[rptr];
  assign pop     = TxValid & TxReady;
  assign push    = MemWrite & is_mmio & (sel == 2'd2);
  // A full FIFO still takes a byte when the head leaves the same edge.
  assign do_push = push & (!full | pop);

  assign cnt5   = 5'(count);
  assign status = {24'b0, cnt5[3:0], 1'b0, ovf, full, empty};

  always_comb begin
    ReadData = 32'h0;
    unique case (1'b1)
      is_ram:  ReadData = mem[idx];
      is_mmio: begin
        unique case (sel)
          2'd0:    ReadData = cycle;
          2'd1:    ReadData = Leds;
          2'd2:    ReadData = 32'h0;
          default: ReadData = status;
        endcase
      end
      default: ReadData = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (MemWrite && is_ram && !reset)
      mem[idx] <= WriteData;
    if (do_push && !reset)
      fifo[wptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
      Leds  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (MemWrite && is_mmio && sel == 2'd1)
        Leds <= WriteData;
      if (do_push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (MemWrite && is_mmio && sel == 2'd3 && WriteData[2])
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xrisc_data_responder.sv
// tb_xrisc_data_responder: directed vectors against hand-computed
// values for RAM, CYCLE, LEDS and the transmit FIFO.
module tb_xrisc_data_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] Leds;
  logic        TxValid;
  logic [7:0]  TxData;
  logic        TxReady;

  int vectors = 0;
  int fails   = 0;

  localparam logic [31:0] A_CYC = 32'hFFFF0000;
  localparam logic [31:0] A_LED = 32'hFFFF0004;
  localparam logic [31:0] A_TX  = 32'hFFFF0008;
  localparam logic [31:0] A_ST  = 32'hFFFF000C;

  xrisc_data_responder #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData),
    .ReadData(ReadData), .Leds(Leds), .TxValid(TxValid),
    .TxData(TxData), .TxReady(TxReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    DataAdr = a;
    #1;
    chk(tag, ReadData, exp);
  endtask

  initial begin
    logic [7:0] drain [8];
    reset = 1'b1; MemWrite = 1'b0; TxReady = 1'b0;
    DataAdr = 32'h0; WriteData = 32'h0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_leds", Leds, 32'h0);
    chk("rst_txvalid", {31'b0, TxValid}, 32'h0);
    rd("rst_status", A_ST, 32'h1);
    rd("rst_cycle0", A_CYC, 32'h0);
    step(); step(); step();
    rd("cycle3", A_CYC, 32'h3);

    wr(32'h20, 32'hDEADBEEF);
    rd("ram_20", 32'h20, 32'hDEADBEEF);
    rd("ram_23", 32'h23, 32'hDEADBEEF);
    rd("ram_alias", 32'h120, 32'hDEADBEEF);
    rd("unmapped", 32'h00020000, 32'h0);
    wr(32'h40, 32'h12345678);
    wr(32'h10000040, 32'hFFFFFFFF);
    rd("ignored_wr", 32'h40, 32'h12345678);
    wr(A_LED, 32'hA5A5_0F0F);
    chk("leds", Leds, 32'hA5A5_0F0F);
    rd("leds_rd", A_LED, 32'hA5A5_0F0F);
    rd("txdata_rd", A_TX, 32'h0);

    TxReady = 1'b0;
    wr(A_TX, 32'h41);
    wr(A_TX, 32'h42);
    wr(A_TX, 32'h43);
    rd("st_three", A_ST, 32'h30);
    TxReady = 1'b1;
    #1;
    chk("order_v0", {31'b0, TxValid}, 32'h1);
    chk("order_d0", {24'b0, TxData}, 32'h41);
    step();
    chk("order_d1", {24'b0, TxData}, 32'h42);
    step();
    chk("order_d2", {24'b0, TxData}, 32'h43);
    step();
    TxReady = 1'b0;
    chk("order_empty", {31'b0, TxValid}, 32'h0);
    rd("st_drained", A_ST, 32'h1);

    for (int i = 0; i < 9; i++) wr(A_TX, 32'(i));
    rd("st_ovf", A_ST, 32'h86);
    chk("head_00", {24'b0, TxData}, 32'h00);
    TxReady = 1'b1;
    wr(A_TX, 32'h55);
    TxReady = 1'b0;
    rd("st_full_pp", A_ST, 32'h86);
    wr(A_ST, 32'h4);
    rd("st_ovf_clr", A_ST, 32'h82);
    drain = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h55};
    TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain_v%0d", i), {31'b0, TxValid}, 32'h1);
      chk($sformatf("drain_d%0d", i), {24'b0, TxData}, {24'b0, drain[i]});
      step();
    end
    TxReady = 1'b0;
    chk("drain_empty", {31'b0, TxValid}, 32'h0);
    rd("st_after", A_ST, 32'h1);

    wr(A_TX, 32'h61);
    wr(A_TX, 32'h62);
    wr(A_TX, 32'h63);
    chk("pre_rst_v", {31'b0, TxValid}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_v", {31'b0, TxValid}, 32'h0);
    rd("mid_rst_st", A_ST, 32'h1);
    chk("mid_rst_leds", Leds, 32'h0);
    rd("mid_rst_cyc", A_CYC, 32'h0);
    rd("mid_rst_ram", 32'h40, 32'h12345678);
    rd("mid_rst_ram2", 32'h20, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
